// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side FWFT buffer behind the Uart8 receiver. Captures
//               one byte per rxDone rising edge, tags it with rxErr, and
//               presents the head entry through a valid/ready handshake.
//               Optional build macro RX_FIFO_DROP_ERR_EN discards bytes
//               received with rxErr=1 and ties outErr low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxDone,
    input  logic                  rxErr,
    input  logic [7:0]            rxByte,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [7:0]            outByte,
    output logic                  outErr,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  clearOverflow
);

    localparam int c_DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef RX_FIFO_DROP_ERR_EN
    localparam int c_ENTRY_W = 8;
`else
    localparam int c_ENTRY_W = 9;
`endif

    logic [c_ENTRY_W-1:0]  r_mem_q [0:c_DEPTH_N-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [DEPTH_LOG2-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [DEPTH_LOG2:0]   r_count_q,  w_count_d;
    logic                  r_overflow_q, w_overflow_d;
    logic                  r_rx_done_prev_q;

    logic                  w_push_req;
    logic                  w_store_req;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_pop;
    logic [c_ENTRY_W-1:0]  w_entry;
    logic [c_ENTRY_W-1:0]  w_head;

    // Rising edge of rxDone; prev resets high so a level held through reset is ignored
    assign w_push_req = rxDone & ~r_rx_done_prev_q;

`ifdef RX_FIFO_DROP_ERR_EN
    assign w_store_req = w_push_req & ~rxErr;
    assign w_entry     = rxByte;
    assign outByte     = w_head;
    assign outErr      = 1'b0;
`else
    assign w_store_req = w_push_req;
    assign w_entry     = {rxErr, rxByte};
    assign outByte     = w_head[7:0];
    assign outErr      = w_head[8];
`endif

    // Status flags come from the stored count only, never from outReady
    assign outValid = (r_count_q != '0);
    assign empty    = (r_count_q == '0);
    assign full     = (r_count_q == c_DEPTH);
    assign count    = r_count_q;
    assign overflow = r_overflow_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
    assign w_pop     = outValid & outReady;
    assign w_push_ok = w_store_req & (~full | w_pop);
    assign w_drop    = w_store_req & full & ~w_pop;
    assign w_head    = r_mem_q[r_rd_ptr_q];

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = (r_overflow_q & ~clearOverflow) | w_drop;
        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    // Control state registers; reset overrides any concurrent push or pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q       <= '0;
            r_rd_ptr_q       <= '0;
            r_count_q        <= '0;
            r_overflow_q     <= 1'b0;
            r_rx_done_prev_q <= 1'b1;
        end else begin
            r_wr_ptr_q       <= w_wr_ptr_d;
            r_rd_ptr_q       <= w_rd_ptr_d;
            r_count_q        <= w_count_d;
            r_overflow_q     <= w_overflow_d;
            r_rx_done_prev_q <= rxDone;
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem_q[r_wr_ptr_q] <= w_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed bench for uart_rx_fifo with a queue-based reference
//               model checked every cycle plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset;
    logic                rxDone;
    logic                rxErr;
    logic [7:0]          rxByte;
    logic                outValid;
    logic                outReady;
    logic [7:0]          outByte;
    logic                outErr;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                clearOverflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [8:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_prev = 1'b1;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxDone        (rxDone),
        .rxErr         (rxErr),
        .rxByte        (rxByte),
        .outValid      (outValid),
        .outReady      (outReady),
        .outByte       (outByte),
        .outErr        (outErr),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .clearOverflow (clearOverflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare at negedge
    task automatic tick();
        int sz;
        bit push, pop, drop;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            sz   = mq.size();
            push = rxDone && !m_prev;
`ifdef RX_FIFO_DROP_ERR_EN
            if (rxErr) push = 1'b0;
`endif
            m_prev = rxDone;
            pop  = (sz > 0) && outReady;
            drop = push && (sz == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back({rxErr, rxByte});
            m_ovf = (m_ovf && !clearOverflow) || drop;
        end
        @(negedge clk);
        chk("outValid", {31'b0, outValid}, {31'b0, mq.size() != 0});
        chk("count",    {27'b0, count},    mq.size());
        chk("full",     {31'b0, full},     {31'b0, mq.size() == DEPTH});
        chk("empty",    {31'b0, empty},    {31'b0, mq.size() == 0});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (mq.size() > 0) begin
            chk("outByte", {24'b0, outByte}, {24'b0, mq[0][7:0]});
            chk("outErr",  {31'b0, outErr},  {31'b0, mq[0][8]});
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic e);
        rxByte = b;
        rxErr  = e;
        rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
        tick();
    endtask

    task automatic drain_all();
        outReady = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        outReady = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        outReady = 1'b0; clearOverflow = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk("rst_outValid", {31'b0, outValid}, 32'd0);
        chk("rst_count",    {27'b0, count},    32'd0);
        chk("rst_empty",    {31'b0, empty},    32'd1);
        chk("rst_full",     {31'b0, full},     32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        reset = 1'b0;
        tick();

        // Single byte: visible the cycle after the rxDone rise
        rxByte = 8'h55; rxDone = 1'b1;
        tick();
        chk("t1_outValid", {31'b0, outValid}, 32'd1);
        chk("t1_outByte",  {24'b0, outByte},  32'h55);
        chk("t1_outErr",   {31'b0, outErr},   32'd0);
        chk("t1_count",    {27'b0, count},    32'd1);
        rxDone = 1'b0;
        tick();
        outReady = 1'b1;
        tick();
        chk("t1_count0", {27'b0, count}, 32'd0);
        chk("t1_empty",  {31'b0, empty}, 32'd1);
        tick();                               // outReady while empty is ignored
        outReady = 1'b0;

        // Error tag
        push_byte(8'hA3, 1'b1);
`ifdef RX_FIFO_DROP_ERR_EN
        chk("t2_outValid", {31'b0, outValid}, 32'd0);
        chk("t2_count",    {27'b0, count},    32'd0);
        chk("t2_overflow", {31'b0, overflow}, 32'd0);
`else
        chk("t2_outErr",  {31'b0, outErr},  32'd1);
        chk("t2_outByte", {24'b0, outByte}, 32'hA3);
`endif
        drain_all();

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
        chk("t3_full",  {31'b0, full},  32'd1);
        chk("t3_count", {27'b0, count}, 32'd16);
        push_byte(8'hFF, 1'b0);
        chk("t3_overflow", {31'b0, overflow}, 32'd1);
        chk("t3_count16",  {27'b0, count},    32'd16);
        outReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", {24'b0, outByte}, i);
            tick();
        end
        outReady = 1'b0;
        chk("t3_empty", {31'b0, empty}, 32'd1);
        clearOverflow = 1'b1;
        tick();
        clearOverflow = 1'b0;
        chk("t3_ovf_clr", {31'b0, overflow}, 32'd0);

        // Full with simultaneous pop and push
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b0);
        rxByte = 8'h77; rxDone = 1'b1; outReady = 1'b1;
        tick();
        rxDone = 1'b0; outReady = 1'b0;
        chk("t4_count",    {27'b0, count},    32'd16);
        chk("t4_overflow", {31'b0, overflow}, 32'd0);
        tick();
        outReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_drain", {24'b0, outByte}, (i < DEPTH - 1) ? (32'h11 + i) : 32'h77);
            tick();
        end
        outReady = 1'b0;

        // Push and pop together at count 1
        push_byte(8'h21, 1'b0);
        rxByte = 8'h22; rxDone = 1'b1; outReady = 1'b1;
        tick();
        rxDone = 1'b0; outReady = 1'b0;
        chk("t7_outValid", {31'b0, outValid}, 32'd1);
        chk("t7_outByte",  {24'b0, outByte},  32'h22);
        chk("t7_count",    {27'b0, count},    32'd1);
        drain_all();

        // Held rxDone gives one entry; reset while held gives none
        rxByte = 8'h3C; rxDone = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_count1", {27'b0, count}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_count0", {27'b0, count}, 32'd0);
        rxDone = 1'b0;
        tick();
        rxByte = 8'h4D; rxDone = 1'b1;
        tick();
        chk("t5_repush", {27'b0, count},   32'd1);
        chk("t5_byte",   {24'b0, outByte}, 32'h4D);
        rxDone = 1'b0;
        drain_all();

        // Overflow set beats clear in the same cycle
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i), 1'b0);
        rxByte = 8'hEE; rxDone = 1'b1; clearOverflow = 1'b1;
        tick();
        chk("t6_set_wins", {31'b0, overflow}, 32'd1);
        rxDone = 1'b0;
        tick();
        chk("t6_cleared", {31'b0, overflow}, 32'd0);
        clearOverflow = 1'b0;
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
